// File: rtl/sample_ntt.sv
// ML-KEM SampleNTT rejection sampler: 64-bit SHAKE128 lanes in,
// 12-bit coefficients below Q out to the polynomial RAM write port.
module sample_ntt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] lane_i,
  input  logic        lane_valid_i,
  output logic        lane_ready_o,
  output logic [11:0] coef_o,
  output logic [7:0]  coef_idx_o,
  output logic        coef_valid_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [11:0] Q = 12'd3329;
  localparam logic [7:0]  LAST = 8'd255;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [79:0] buf_q;
  logic [3:0]  cnt_q;
  logic        ph_q;
  logic [11:0] h_q;
  logic [7:0]  idx_q;
  logic [11:0] coef_q;
  logic [7:0]  coef_idx_q;
  logic        coef_valid_q;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  b0, b1, b2;
  logic [11:0] d1, cand;
  logic [79:0] lane_ext;
  logic        run, ld, pop, cand_vld, acc, last;

  always_comb begin
    b0       = buf_q[7:0];
    b1       = buf_q[15:8];
    b2       = buf_q[23:16];
    d1       = {b1[3:0], b0};
    run      = (state_q == RUN);
    ld       = lane_ready_o && lane_valid_i;
    pop      = run && !ph_q && (cnt_q >= 4'd3);
    cand_vld = run && (pop || ph_q);
    cand     = ph_q ? h_q : d1;
    acc      = cand_vld && (cand < Q);
    last     = acc && (idx_q == LAST);
    // new lane lands directly behind the bytes already held
    lane_ext = {16'h0, lane_i} << {cnt_q, 3'b000};
  end

  assign lane_ready_o = (state_q == RUN) && (cnt_q <= 4'd2);
  assign coef_o       = coef_q;
  assign coef_idx_o   = coef_idx_q;
  assign coef_valid_o = coef_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      cnt_q        <= '0;
      ph_q         <= 1'b0;
      h_q          <= '0;
      idx_q        <= '0;
      coef_q       <= '0;
      coef_idx_q   <= '0;
      coef_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      coef_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (start_i) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        buf_q   <= '0;
        cnt_q   <= '0;
        ph_q    <= 1'b0;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        if (ld) begin
          buf_q <= buf_q | lane_ext;
          cnt_q <= cnt_q + 4'd8;
        end
        if (pop) begin
          buf_q <= buf_q >> 24;
          cnt_q <= cnt_q - 4'd3;
          h_q   <= {b2, b1[7:4]};
          ph_q  <= 1'b1;
        end else if (ph_q) begin
          ph_q <= 1'b0;
        end
        if (acc) begin
          coef_q       <= cand;
          coef_idx_q   <= idx_q;
          coef_valid_q <= 1'b1;
          idx_q        <= idx_q + 8'd1;
        end
        // final coefficient: drop any pending d2 and leftover bytes
        if (last) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_ntt.sv
// Bench for sample_ntt: random lane stream against a byte-queue
// model of the SampleNTT parse, plus directed boundary runs.
module tb_sample_ntt;

  logic        clk = 1'b0;
  logic        rst, start, lane_valid;
  logic [63:0] lane;
  logic        lane_ready_o;
  logic [11:0] coef_o;
  logic [7:0]  coef_idx_o;
  logic        coef_valid_o, busy_o, done_o;

  always #5 clk = ~clk;

  sample_ntt dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .lane_i       (lane),
    .lane_valid_i (lane_valid),
    .lane_ready_o (lane_ready_o),
    .coef_o       (coef_o),
    .coef_idx_o   (coef_idx_o),
    .coef_valid_o (coef_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  bq[$];
  int          eq[$];
  logic [63:0] lq[$];
  int          produced;

  function automatic void model_push(input logic [63:0] l);
    int x0, x1, x2, c1, c2;
    for (int k = 0; k < 8; k++) bq.push_back(l[8*k +: 8]);
    while (bq.size() >= 3) begin
      x0 = int'(bq.pop_front());
      x1 = int'(bq.pop_front());
      x2 = int'(bq.pop_front());
      c1 = x0 + 256 * (x1 % 16);
      c2 = (x1 / 16) + 16 * x2;
      if (c1 < 3329 && produced < 256) begin
        eq.push_back(c1);
        produced++;
      end
      if (c2 < 3329 && produced < 256) begin
        eq.push_back(c2);
        produced++;
      end
    end
  endfunction

  function automatic logic [63:0] next_lane(input int mode);
    logic [63:0] l;
    l = '0;
    if (lq.size() > 0) return lq.pop_front();
    if (mode == 1) return l;
    for (int k = 0; k < 8; k++)
      case ($urandom_range(0, 5))
        0: l[8*k +: 8] = 8'h00;
        1: l[8*k +: 8] = 8'h0D;
        2: l[8*k +: 8] = 8'hFF;
        3: l[8*k +: 8] = 8'h0C;
        default: l[8*k +: 8] = 8'($urandom);
      endcase
    return l;
  endfunction

  task automatic check_quiet(input string tag);
    expect_eq({tag, "_valid"}, coef_valid_o, 0);
    expect_eq({tag, "_done"}, done_o, 0);
    expect_eq({tag, "_busy"}, busy_o, 0);
    expect_eq({tag, "_ready"}, lane_ready_o, 0);
  endtask

  // kind: 0 plain, 1 reset after `at` coefs, 2 restart after `at` coefs
  task automatic run_poly(input int mode, input int kind, input int at,
                          input bit lat_chk);
    int got, cyc, dones, v0;
    bit fin, have;
    logic [63:0] cur;
    got = 0; cyc = 0; dones = 0; v0 = 0; fin = 0; have = 0; cur = '0;
    bq.delete(); eq.delete(); produced = 0;
    start = 1'b1; lane_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    expect_eq("first_ready", lane_ready_o, 1);
    expect_eq("run_busy", busy_o, 1);
    while (!fin && cyc < 4000) begin
      if (coef_valid_o) begin
        if (eq.size() == 0) expect_eq("coef_extra", coef_valid_o, 0);
        else expect_eq("coef", coef_o, eq.pop_front());
        expect_eq("idx", coef_idx_o, got);
        if (got == 0) v0 = cyc;
        if (got == 1 && lat_chk) expect_eq("lat_consec", cyc - v0, 1);
        got++;
        if (done_o) dones++;
        expect_eq("done_at_last", done_o, got == 256);
        expect_eq("busy_at_coef", busy_o, got != 256);
        if (got == 256) fin = 1;
      end else begin
        expect_eq("done_no_coef", done_o, 0);
      end
      if (fin) break;
      if (kind != 0 && got >= at) begin
        lane_valid = 1'b0;
        if (kind == 1) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check_quiet("rst_mid");
          expect_eq("rst_coef", coef_o, 0);
          expect_eq("rst_idx", coef_idx_o, 0);
          return;
        end
        start = 1'b1;
        bq.delete(); eq.delete(); lq.delete();
        produced = 0; got = 0; have = 0; kind = 0;
        @(negedge clk);
        start = 1'b0;
        cyc++;
        continue;
      end
      if (!have) begin
        cur = next_lane(mode);
        have = 1;
      end
      lane = cur;
      lane_valid = ($urandom_range(0, 3) != 0);
      if (lane_valid && lane_ready_o) begin
        model_push(cur);
        have = 0;
      end
      @(negedge clk);
      cyc++;
    end
    lane_valid = 1'b0;
    expect_eq("complete", got, 256);
    expect_eq("done_count", dones, 1);
    repeat (3) begin
      @(negedge clk);
      check_quiet("after_done");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; lane_valid = 1'b0; lane = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    expect_eq("reset_coef", coef_o, 0);
    expect_eq("reset_idx", coef_idx_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // AB 5A 8B | 00 0D 00 | 01 0D 00 | FF FF FF | FF 0F 00 across lanes
    lq.push_back({8'h0D, 8'h01, 8'h00, 8'h0D, 8'h00, 8'h8B, 8'h5A, 8'hAB});
    lq.push_back({8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00});
    run_poly(0, 0, 0, 1'b1);

    run_poly(1, 0, 0, 1'b0);

    // one early reject leaves idx 255 on a d1 with its d2 dropped
    lq.push_back({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF});
    run_poly(1, 0, 0, 1'b0);

    run_poly(0, 1, 40, 1'b0);
    @(negedge clk);
    run_poly(0, 2, 60, 1'b0);
    for (int r = 0; r < 3; r++) run_poly(0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
